// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter state encoding
// and the nominal line timing used to size frames.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_t;

  localparam int unsigned UART_CLK_HZ    = 100000000;
  localparam int unsigned UART_BIT_RATE  = 115200;
  localparam int unsigned UART_BIT_CYC   = UART_CLK_HZ / UART_BIT_RATE;
  // start + 8 data + stop
  localparam int unsigned UART_FRAME_CYC = 10 * UART_BIT_CYC;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: returns the first set request
// at or above rr_ptr, searching upward and wrapping to index 0.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    winner,
  output logic               any_valid
);

  int unsigned     sum;
  logic [ID_W-1:0] idx;

  // Walk the requests starting at the pointer; the first hit wins.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    sum       = 0;
    idx       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sum = 32'(rr_ptr) + i;
      if (sum >= NUM_REQ) begin
        sum = sum - NUM_REQ;
      end
      idx = ID_W'(sum);
      if (!any_valid && req[idx]) begin
        winner    = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte
// producers, with per-requester packet lock and a launch watchdog.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ID_W      = $clog2(NUM_REQ),
  parameter int unsigned BUSY_WAIT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_lock,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 tx_busy,
  output logic                 tx_enable,
  output logic [7:0]           tx_data,
  output logic [ID_W-1:0]      grant_id,
  output logic                 active,
  output logic                 timeout_err
);

  import uart_pkg::*;

  localparam int unsigned WD_W = $clog2(BUSY_WAIT + 1);

  arb_state_t      state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] lock_id;
  logic            lock_vld;
  logic [WD_W-1:0] wd_cnt;

  logic [ID_W-1:0] rr_win;
  logic [ID_W-1:0] winner;
  logic            any_valid;
  logic            owner_valid;
  logic            launch_ok;
  logic [7:0]      win_byte;

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] id);
    return (id == ID_W'(NUM_REQ - 1)) ? '0 : id + 1'b1;
  endfunction

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .winner    (rr_win),
    .any_valid (any_valid)
  );

  assign tx_enable = (state == ST_LAUNCH);
  assign active    = (state != ST_IDLE);

  // Winner selection and Mealy ready: a valid lock owner overrides round-robin.
  always_comb begin
    owner_valid = lock_vld && req_valid[lock_id];
    winner      = owner_valid ? lock_id : rr_win;
    launch_ok   = (state == ST_IDLE) && !tx_busy && any_valid;
    req_ready   = '0;
    if (launch_ok) begin
      req_ready[winner] = 1'b1;
    end
    win_byte = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == winner) begin
        win_byte = req_data[i*8 +: 8];
      end
    end
  end

  // Arbitration FSM, watchdog and lock/pointer bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      tx_data     <= '0;
      grant_id    <= '0;
      rr_ptr      <= '0;
      lock_id     <= '0;
      lock_vld    <= 1'b0;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          // An owner that stops offering bytes forfeits its hold.
          if (lock_vld && !req_valid[lock_id]) begin
            lock_vld <= 1'b0;
          end
          if (launch_ok) begin
            tx_data  <= win_byte;
            grant_id <= winner;
            state    <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          wd_cnt <= '0;
          state  <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (tx_busy) begin
            state <= ST_WAIT_DONE;
          end else if (wd_cnt == WD_W'(BUSY_WAIT - 1)) begin
            timeout_err <= 1'b1;
            lock_vld    <= 1'b0;
            rr_ptr      <= wrap_inc(grant_id);
            state       <= ST_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy) begin
            state <= ST_IDLE;
            if (req_lock[grant_id]) begin
              lock_vld <= 1'b1;
              lock_id  <= grant_id;
            end else begin
              lock_vld <= 1'b0;
              rr_ptr   <= wrap_inc(grant_id);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small transmitter model and
// per-requester byte queues.
module tb_uart_tx_arbiter;

  localparam int unsigned NR = 4;

  logic            clk;
  logic            reset;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_lock;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            tx_busy;
  logic            tx_enable;
  logic [7:0]      tx_data;
  logic [1:0]      grant_id;
  logic            active;
  logic            timeout_err;

  uart_tx_arbiter #(
    .NUM_REQ   (4),
    .ID_W      (2),
    .BUSY_WAIT (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_lock    (req_lock),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_busy     (tx_busy),
    .tx_enable   (tx_enable),
    .tx_data     (tx_data),
    .grant_id    (grant_id),
    .active      (active),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks;
  int unsigned n_bad;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Transmitter model: busy rises ~2 cycles after enable, lasts tm_len cycles.
  logic        tm_busy;
  logic        busy_force;
  logic        tm_never;
  int unsigned tm_len;
  int unsigned tm_cnt;
  logic [1:0]  tm_ph;

  assign tx_busy = tm_busy | busy_force;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      tm_busy <= 1'b0;
      tm_ph   <= 2'd0;
      tm_cnt  <= 0;
    end else begin
      case (tm_ph)
        2'd0: if (tx_enable && !tm_never) begin tm_ph <= 2'd1; tm_cnt <= 1; end
        2'd1: if (tm_cnt == 2) begin tm_busy <= 1'b1; tm_ph <= 2'd2; tm_cnt <= 1; end
              else tm_cnt <= tm_cnt + 1;
        2'd2: if (tm_cnt == tm_len) begin tm_busy <= 1'b0; tm_ph <= 2'd0; end
              else tm_cnt <= tm_cnt + 1;
        default: tm_ph <= 2'd0;
      endcase
    end
  end

  // Launch log plus a counter of tx_data changes while a frame is busy.
  logic [7:0]  log_data [16];
  logic [1:0]  log_gid  [16];
  int unsigned log_n;
  int unsigned stab_err;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      log_n    = 0;
      stab_err = 0;
    end else begin
      if (active && tm_busy && log_n > 0 && tx_data !== log_data[log_n-1]) stab_err++;
      if (tx_enable && log_n < 16) begin
        log_data[log_n] = tx_data;
        log_gid[log_n]  = grant_id;
        log_n++;
      end
    end
  end

  // Requester queues: each entry is a byte and the lock level to hold after it.
  logic [7:0]  q_data [NR][8];
  logic        q_lock [NR][8];
  int unsigned q_len  [NR];
  int unsigned q_pos  [NR];
  logic [NR-1:0] lock_hold;
  logic [NR-1:0] hs;

  initial begin
    req_valid = '0;
    req_lock  = '0;
    req_data  = '0;
    lock_hold = '0;
    for (int i = 0; i < NR; i++) q_pos[i] = 0;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (reset) begin
          q_pos[i]     = 0;
          lock_hold[i] = 1'b0;
          req_valid[i] = 1'b0;
        end else begin
          if (hs[i] && q_pos[i] < q_len[i]) begin
            lock_hold[i] = q_lock[i][q_pos[i]];
            q_pos[i]++;
          end
          if (q_pos[i] < q_len[i]) begin
            req_valid[i]      = 1'b1;
            req_data[i*8 +: 8] = q_data[i][q_pos[i]];
          end else begin
            req_valid[i] = 1'b0;
          end
        end
        req_lock[i] = lock_hold[i];
      end
    end
  end

  task automatic push(input int r, input logic [7:0] b, input logic lk);
    q_data[r][q_len[r]] = b;
    q_lock[r][q_len[r]] = lk;
    q_len[r]++;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    busy_force = 1'b0;
    tm_never   = 1'b0;
    for (int i = 0; i < NR; i++) q_len[i] = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end while (req_valid == '0 && n < budget);
    check_val(tag, 32'(req_valid != '0), 32'(1));
  endtask

  task automatic wait_busy(input string tag, input logic want, input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end while (tx_busy !== want && n < budget);
    check_val(tag, 32'(tx_busy), 32'(want));
  endtask

  task automatic wait_enable(input string tag, input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end while (tx_enable !== 1'b1 && n < budget);
    check_val(tag, 32'(tx_enable), 32'(1));
  endtask

  task automatic wait_launches(input string tag, input int unsigned want, input int budget);
    int n = 0;
    while (log_n < want && n < budget) begin @(negedge clk); n++; end
    check_val(tag, 32'(log_n), 32'(want));
  endtask

  logic [7:0] exp_fair [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
  logic [7:0] exp_lk_d [5] = '{8'h77, 8'hA1, 8'hA2, 8'hA3, 8'h55};
  logic [1:0] exp_lk_g [5] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd0};

  initial begin : guard
    #400000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int cnt;
    n_checks   = 0;
    n_bad      = 0;
    reset      = 1'b1;
    busy_force = 1'b0;
    tm_never   = 1'b0;
    tm_len     = 100;
    for (int i = 0; i < NR; i++) q_len[i] = 0;
    repeat (3) @(negedge clk);

    check_val("rst_tx_enable", 32'(tx_enable), 32'(0));
    check_val("rst_tx_data", 32'(tx_data), 32'(0));
    check_val("rst_grant_id", 32'(grant_id), 32'(0));
    check_val("rst_active", 32'(active), 32'(0));
    check_val("rst_timeout", 32'(timeout_err), 32'(0));
    check_val("rst_ready", 32'(req_ready), 32'(0));
    reset = 1'b0;

    // Single requester
    push(0, 8'hAA, 1'b0);
    wait_valid("t1_valid", 20);
    check_val("t1_ready_c0", 32'(req_ready), 32'h1);
    @(negedge clk);
    check_val("t1_enable_c1", 32'(tx_enable), 32'(1));
    check_val("t1_data", 32'(tx_data), 32'hAA);
    check_val("t1_active", 32'(active), 32'(1));
    @(negedge clk);
    check_val("t1_enable_c2", 32'(tx_enable), 32'(0));
    wait_busy("t1_busy_up", 1'b1, 20);
    wait_busy("t1_busy_down", 1'b0, 200);
    check_val("t1_active_last", 32'(active), 32'(1));
    @(negedge clk);
    check_val("t1_active_end", 32'(active), 32'(0));
    check_val("t1_pulses", 32'(log_n), 32'(1));
    check_val("t1_data_hold", 32'(tx_data), 32'hAA);

    // Fairness
    do_reset();
    tm_len = 10;
    for (int i = 0; i < NR; i++)
      for (int k = 0; k < 6; k++) push(i, 8'(8'h11 * (i + 1)), 1'b0);
    wait_launches("t2_launches", 5, 600);
    for (int k = 0; k < 5; k++) check_val($sformatf("t2_order%0d", k), 32'(log_data[k]), 32'(exp_fair[k]));
    check_val("t2_stable", 32'(stab_err), 32'(0));

    // Lock
    do_reset();
    push(1, 8'h77, 1'b0);
    wait_launches("t3_first", 1, 50);
    push(0, 8'h55, 1'b0);
    push(2, 8'hA1, 1'b1);
    push(2, 8'hA2, 1'b1);
    push(2, 8'hA3, 1'b0);
    wait_launches("t3_launches", 5, 600);
    for (int k = 0; k < 5; k++) begin
      check_val($sformatf("t3_data%0d", k), 32'(log_data[k]), 32'(exp_lk_d[k]));
      check_val($sformatf("t3_gid%0d", k), 32'(log_gid[k]), 32'(exp_lk_g[k]));
    end

    // Timeout
    do_reset();
    tm_never = 1'b1;
    push(0, 8'h5A, 1'b0);
    push(0, 8'h5C, 1'b0);
    push(1, 8'h6B, 1'b0);
    wait_enable("t4_launch", 20);
    check_val("t4_data", 32'(tx_data), 32'h5A);
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (timeout_err !== 1'b1 && cnt < 40);
    check_val("t4_delay", 32'(cnt), 32'(17));
    check_val("t4_active", 32'(active), 32'(0));
    check_val("t4_next_ready", 32'(req_ready), 32'h2);
    @(negedge clk);
    check_val("t4_pulse_end", 32'(timeout_err), 32'(0));
    check_val("t4_relaunch", 32'(tx_enable), 32'(1));
    check_val("t4_data2", 32'(tx_data), 32'h6B);
    check_val("t4_gid2", 32'(grant_id), 32'(1));

    // Reset mid-frame
    do_reset();
    tm_len = 40;
    push(2, 8'h99, 1'b0);
    wait_busy("t5_busy_up", 1'b1, 30);
    repeat (2) @(negedge clk);
    check_val("t5_active_pre", 32'(active), 32'(1));
    check_val("t5_gid_pre", 32'(grant_id), 32'(2));
    #2;
    reset = 1'b1;
    #1;
    check_val("t5_active", 32'(active), 32'(0));
    check_val("t5_tx_data", 32'(tx_data), 32'(0));
    check_val("t5_grant_id", 32'(grant_id), 32'(0));
    check_val("t5_tx_enable", 32'(tx_enable), 32'(0));
    check_val("t5_ready", 32'(req_ready), 32'(0));
    for (int i = 0; i < NR; i++) q_len[i] = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    push(3, 8'hD3, 1'b0);
    push(0, 8'hD0, 1'b0);
    wait_valid("t5_valid", 20);
    check_val("t5_restart_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    check_val("t5_restart_data", 32'(tx_data), 32'hD0);

    // Launch blocked by busy
    do_reset();
    busy_force = 1'b1;
    push(3, 8'h3C, 1'b0);
    wait_valid("t6_valid", 20);
    check_val("t6_blocked0", 32'(req_ready), 32'(0));
    repeat (3) @(negedge clk);
    check_val("t6_blocked3", 32'(req_ready), 32'(0));
    check_val("t6_idle", 32'(active), 32'(0));
    busy_force = 1'b0;
    #1;
    check_val("t6_ready", 32'(req_ready), 32'h8);
    @(negedge clk);
    check_val("t6_enable", 32'(tx_enable), 32'(1));
    check_val("t6_data", 32'(tx_data), 32'h3C);
    check_val("t6_gid", 32'(grant_id), 32'(3));

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter in `top` among `NUM_REQ` byte-producing requesters. Each requester offers a byte through a valid/ready handshake. The arbiter latches the winning byte, drives the transmitter's `parallel_in`/`t_enable`, and tracks `busy` until the frame completes. A per-requester lock keeps multi-byte packets from interleaving, and a watchdog recovers if the transmitter never acknowledges.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ID_W`, `$clog2(NUM_REQ)`: width of the grant index.
- `BUSY_WAIT`, 16: cycles to wait for `tx_busy` to rise after launch before declaring a timeout.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock (100 MHz).
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester byte-offered flag.
- `req_lock`  in  NUM_REQ  per-requester packet hold; keeps the grant while high.
- `req_data`  in  8*NUM_REQ  bytes; requester i owns bits `[8i+7:8i]`.
- `req_ready`  out  NUM_REQ  one-hot accept; a transfer happens when valid & ready.
- `tx_busy`  in  1  transmitter `busy`.
- `tx_enable`  out  1  to transmitter `t_enable`; one-cycle launch pulse.
- `tx_data`  out  8  to transmitter `parallel_in`; held stable from launch until done.
- `grant_id`  out  ID_W  index of the current or last granted requester.
- `active`  out  1  high whenever the FSM is not in IDLE.
- `timeout_err`  out  1  one-cycle pulse when the watchdog expires.

## Operation
States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.

- **IDLE**
  - If no `req_valid` bit is set, stay in IDLE.
  - Otherwise select a winner:
    - If `lock_own` is set and that requester is valid, it wins.
    - Otherwise the first valid requester at or after `rr_ptr`, searching upward with wrap, wins.
  - `req_ready[winner]` is asserted combinationally in the same cycle.
  - On the transfer: latch `req_data[winner]` into `tx_data`, set `grant_id` = winner, go to LAUNCH.
- **LAUNCH**
  - `tx_enable` = 1 for exactly this cycle.
  - Clear the watchdog counter; go to WAIT_BUSY.
- **WAIT_BUSY**
  - `tx_busy` = 1 → go to WAIT_DONE.
  - Counter reaches `BUSY_WAIT`-1 with `tx_busy` still 0 → pulse `timeout_err`, clear `lock_own`, go to IDLE. `rr_ptr` still advances.
- **WAIT_DONE**
  - `tx_busy` = 0 → go to IDLE.
  - On this exit:
    - If `req_lock[grant_id]` = 1, set `lock_own` = `grant_id` and leave `rr_ptr` unchanged.
    - Else clear `lock_own` and set `rr_ptr` = `grant_id`+1, wrapping modulo `NUM_REQ`.

Boundary rules:
- **Lock dropped while owner is idle.** If `lock_own` is set but the owner is not valid in IDLE, release `lock_own` and arbitrate normally.
- **Lock only holds after a byte.** `req_lock` is sampled only at WAIT_DONE exit. A lock raised without a byte in flight has no effect.
- **Mid-frame changes are ignored.** Changes on `req_valid`/`req_data` outside IDLE have no effect.
- **Busy already high at launch.** If `tx_busy` is already 1 at LAUNCH (transmitter still draining), WAIT_BUSY exits the next cycle. The arbiter does not enter LAUNCH while `tx_busy` = 1; IDLE stays put until `tx_busy` = 0.
- **Reset mid-frame.** Outputs return to reset values immediately. The transmitter frame in progress is abandoned and not retried.

## Timing
- Reset values: state IDLE, `tx_enable` 0, `tx_data` 8'h00, `grant_id` 0, `rr_ptr` 0, `lock_own` cleared, `active` 0, `timeout_err` 0; `req_ready` 0 because IDLE has no valid requester at reset.
- Latency from valid request in IDLE with `tx_busy` = 0:
  - ready in cycle 0;
  - `tx_enable` in cycle 1;
  - WAIT_BUSY entered at cycle 2.
- Minimum gap between `tx_enable` pulses is the frame length + 3 cycles (about 8680 cycles per 10-bit frame at 115200 baud and 100 MHz).
- `req_ready` is a Mealy output of IDLE and the valid inputs. Requesters must hold valid and data until they see ready.
- All other outputs are registered.

## Structure
- Shared package `uart_pkg`:
  - state enum `arb_state_t`;
  - `UART_CLK_HZ` = 100000000;
  - `UART_BIT_RATE` = 115200;
  - derived `UART_FRAME_CYC`.
- One natural sub-module: `rr_pick`, a combinational round-robin priority encoder. Inputs are the request vector and `rr_ptr`; outputs are the winner index and an any-valid flag.
- The FSM, watchdog counter and lock tracking live in `uart_tx_arbiter`.

## Test plan
- **Single requester.** `req_valid`=4'b0001, `req_data[7:0]`=8'hAA; transmitter model raises busy 2 cycles after enable and holds it 100 cycles → `req_ready`=0001 in cycle 0, one `tx_enable` pulse, `tx_data`=AA, `active` high until busy falls.
- **Fairness.** All four valid continuously with distinct bytes 11/22/33/44 → launch order 11,22,33,44,11; each `tx_data` is stable during its busy period.
- **Lock.** Requester 2 sends 3 bytes with `req_lock[2]`=1 while requester 0 is also valid → all three bytes from requester 2 go out consecutively, then requester 0 (`rr_ptr` wraps 3→0).
- **Timeout.** Transmitter model never asserts busy, `BUSY_WAIT`=16 → `timeout_err` pulses 16 cycles after WAIT_BUSY entry, return to IDLE, next requester granted.
- **Reset mid-frame.** Assert reset during WAIT_DONE → all outputs at reset values asynchronously; after release, arbitration restarts from requester 0.
- **Launch blocked by busy.** `tx_busy` high at request time → no `req_ready` until busy falls, then ready the same cycle busy is 0.
